onebyeight_tdm_demux: RTL and testbench
=======================================

Name: onebyeight_tdm_demux

Overview:
Time-division 1:8 demultiplexer. It is the receive end of an 8:1 mux that time-slots eight WIDTH-bit channels onto one bus. It tracks the slot position from a start-of-frame marker and collects one word per slot into shadow registers. After a full, correctly framed set of eight words, it presents all eight channels together on registered outputs, with a one-cycle frame_valid strobe.

Parameters:
WIDTH, 4, bit width of each channel word and of din.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
din  input  WIDTH  time-multiplexed channel word.
din_valid  input  1  din/sof qualify this cycle; low = idle beat, no state change.
sof  input  1  start of frame; marks the current beat as slot 0 (channel a). Ignored when din_valid=0.
y0..y7  output  WIDTH each  demuxed channels a..h (slot 0..7), registered, held between frames.
frame_valid  output  1  one-cycle pulse: y0..y7 were updated on this cycle's preceding edge.
locked  output  1  1 while in COLLECT state.
sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async, active-high): all of the following clear immediately, with no clock needed:
  - state=HUNT, slot counter=0, shadow regs=0.
  - y0..y7=0, frame_valid=0, locked=0, sync_err=0.
- Accepted beat = rising edge with din_valid=1. Beats with din_valid=0 change nothing. frame_valid and sync_err deassert on any edge where they are not re-asserted.
- Slot counter: 3 bits, 0..7.
- HUNT state:
  - Accepted beat with sof=1: shadow[0]<=din, slot<=1, go COLLECT.
  - Accepted beat with sof=0: discarded, no sync_err.
- COLLECT state, accepted beat:
  - sof=1 and slot==0: normal frame start. Write shadow[0], slot<=1.
  - sof=1 and slot!=0 (early sof): sync_err pulse. The partial frame is discarded; y0..y7 stay unchanged. This beat starts a new frame: shadow[0]<=din, slot<=1, stay COLLECT.
  - sof=0 and slot==0 (missing sof): sync_err pulse, beat discarded, go HUNT.
  - sof=0 and 1<=slot<=6: shadow[slot]<=din, slot<=slot+1.
  - sof=0 and slot==7: on this same edge:
    - y0..y6 load from shadow[0..6] and y7 loads din directly (no extra cycle).
    - frame_valid<=1, slot<=0 (wrap).
- sof=1 at slot 7 counts as early sof: no output update.
- Latency: y0..y7 and frame_valid are visible in the cycle after the 8th accepted beat. Minimum frame period is 8 cycles, and back-to-back frames are supported with no bubble.
- locked is a direct decode of state==COLLECT.
- Outputs y0..y7 change only on a frame completion or on reset.
- Reset mid-frame: partial frame lost, outputs zeroed, back to HUNT.

Test Plan:
1. Assert rst while inputs toggle -> y0..y7=0, frame_valid=0, locked=0, sync_err=0 without waiting for a clock edge.
2. Send 8 consecutive valid beats 6,0,C,1,2,8,9,3 with sof on the first -> one cycle after the 8th beat: frame_valid=1 for exactly one cycle; y0=6, y1=0, y2=C, y3=1, y4=2, y5=8, y6=9, y7=3; locked=1 throughout.
3. Send frame F,5,A,1,2,9,4,3 with din_valid low for 2 cycles after beats 2 and 5 -> frame_valid only after the 8th valid beat; y=F,5,A,1,2,9,4,3; then immediately send E,1,A,5,8,3,6,0 back-to-back -> a second frame_valid exactly 8 cycles after the first.
4. Start a frame; assert sof on the 4th beat (data 7) -> sync_err pulse; y unchanged from the prior frame; the following 7 beats complete a frame with y0=7.
5. After a good frame, send a 9th beat with sof=0 -> sync_err pulse, locked=0. Further sof=0 beats are ignored with no sync_err; a sof beat relocks.
6. Assert rst after 5 beats of a frame -> outputs clear immediately. The next full frame with sof decodes correctly.

Source files
------------

// File: rtl/onebyeight_tdm_demux.sv
// -----------------------------------------------------------------------------
// onebyeight_tdm_demux
//
// Receive end of an 8:1 time-division multiplexer. A start-of-frame marker
// (sof) identifies slot 0. One word per slot is collected into shadow
// registers. When the eighth word of a correctly framed set arrives, all eight
// channels are presented together on registered outputs, with a one-cycle
// frame_valid strobe. Framing violations produce a one-cycle sync_err pulse.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   din          time-multiplexed channel word (WIDTH bits)
//   din_valid    qualifies din/sof; low = idle beat, no state change
//   sof          start of frame; marks the current beat as slot 0
//   y0..y7       demuxed channels a..h (slot 0..7), held between frames
//   frame_valid  one-cycle pulse: y0..y7 were updated on the preceding edge
//   locked       high while in the COLLECT state
//   sync_err     one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module onebyeight_tdm_demux #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]       state;
  logic [2:0]       slot;
  // Slot 7 never needs a shadow: its word goes straight to y7 on the
  // completing edge, so only slots 0..6 are buffered.
  logic [WIDTH-1:0] shadow [0:6];

  assign locked = (state == COLLECT);

  // NOTE: all state, including the shadow array, is updated with non-blocking
  // assignments so every register samples pre-edge values; the shadow array is
  // small and is explicitly cleared on reset so a frame never exposes stale
  // data from before the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= 3'd0;
      for (int i = 0; i < 7; i++) shadow[i] <= '0;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      y4          <= '0;
      y5          <= '0;
      y6          <= '0;
      y7          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      // Strobes drop on every edge that does not re-assert them.
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;

      if (din_valid) begin
        if (state == HUNT) begin
          // Non-sof beats are silently discarded while hunting.
          if (sof) begin
            shadow[0] <= din;
            slot      <= 3'd1;
            state     <= COLLECT;
          end
        end else begin
          if (sof) begin
            // A sof anywhere but slot 0 (including slot 7) abandons the
            // partial frame; the beat itself starts a fresh frame.
            if (slot != 3'd0) sync_err <= 1'b1;
            shadow[0] <= din;
            slot      <= 3'd1;
          end else if (slot == 3'd0) begin
            // Expected a sof here: framing is lost.
            sync_err <= 1'b1;
            state    <= HUNT;
          end else if (slot == 3'd7) begin
            // Last slot: publish the whole frame on this same edge.
            y0          <= shadow[0];
            y1          <= shadow[1];
            y2          <= shadow[2];
            y3          <= shadow[3];
            y4          <= shadow[4];
            y5          <= shadow[5];
            y6          <= shadow[6];
            y7          <= din;
            frame_valid <= 1'b1;
            slot        <= 3'd0;
          end else begin
            shadow[slot] <= din;
            slot         <= slot + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_onebyeight_tdm_demux.sv
// -----------------------------------------------------------------------------
// tb_onebyeight_tdm_demux
//
// Directed test of onebyeight_tdm_demux. A behavioural model tracks the frame
// as a queue of received words and publishes it when eight have arrived; a
// compare process checks every DUT output against the model on each falling
// clock edge. Hand-computed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_onebyeight_tdm_demux;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sof;
  logic [WIDTH-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic             frame_valid;
  logic             locked;
  logic             sync_err;

  int checks = 0;
  int errors = 0;

  onebyeight_tdm_demux #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .y4          (y4),
    .y5          (y5),
    .y6          (y6),
    .y7          (y7),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a frame is just a list of words that began with sof.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] m_y [8];
  logic [WIDTH-1:0] frame_q [$];
  bit               m_locked;
  bit               m_fv;
  bit               m_err;
  int               cycle = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_y[i] = '0;
      frame_q.delete();
      m_locked = 1'b0;
      m_fv     = 1'b0;
      m_err    = 1'b0;
    end else begin
      cycle++;
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (din_valid) begin
        if (!m_locked) begin
          if (sof) begin
            frame_q = {din};
            m_locked = 1'b1;
          end
        end else if (sof) begin
          // Any words already gathered mean this sof arrived too early.
          if (frame_q.size() != 0) m_err = 1'b1;
          frame_q = {din};
        end else if (frame_q.size() == 0) begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end else begin
          frame_q.push_back(din);
          if (frame_q.size() == 8) begin
            for (int i = 0; i < 8; i++) m_y[i] = frame_q[i];
            frame_q.delete();
            m_fv = 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  bit cmp_en = 1'b0;
  int fv_cycles [$];

  always @(negedge clk) begin
    if (cmp_en) begin
      check("y0", y0, m_y[0]);
      check("y1", y1, m_y[1]);
      check("y2", y2, m_y[2]);
      check("y3", y3, m_y[3]);
      check("y4", y4, m_y[4]);
      check("y5", y5, m_y[5]);
      check("y6", y6, m_y[6]);
      check("y7", y7, m_y[7]);
      check("frame_valid", frame_valid, m_fv);
      check("locked", locked, m_locked);
      check("sync_err", sync_err, m_err);
      if (frame_valid) fv_cycles.push_back(cycle);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change just after a rising edge, so they are
  // stable at the next one; literal checks follow each edge by 1 time unit.
  // ---------------------------------------------------------------------------
  task automatic beat(input logic [WIDTH-1:0] d, input logic s);
    din       = d;
    sof       = s;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    sof       = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input logic [4*WIDTH*8-1:0] unused_pad, input logic [WIDTH-1:0] w [8]);
    for (int i = 0; i < 8; i++) beat(w[i], (i == 0));
  endtask

  task automatic check_y(input string tag, input logic [WIDTH-1:0] e [8]);
    check({tag, "_y0"}, y0, e[0]);
    check({tag, "_y1"}, y1, e[1]);
    check({tag, "_y2"}, y2, e[2]);
    check({tag, "_y3"}, y3, e[3]);
    check({tag, "_y4"}, y4, e[4]);
    check({tag, "_y5"}, y5, e[5]);
    check({tag, "_y6"}, y6, e[6]);
    check({tag, "_y7"}, y7, e[7]);
  endtask

  logic [WIDTH-1:0] f2 [8] = '{4'h6, 4'h0, 4'hC, 4'h1, 4'h2, 4'h8, 4'h9, 4'h3};
  logic [WIDTH-1:0] f3 [8] = '{4'hF, 4'h5, 4'hA, 4'h1, 4'h2, 4'h9, 4'h4, 4'h3};
  logic [WIDTH-1:0] f3b[8] = '{4'hE, 4'h1, 4'hA, 4'h5, 4'h8, 4'h3, 4'h6, 4'h0};
  logic [WIDTH-1:0] f4 [8] = '{4'h7, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
  logic [WIDTH-1:0] f6 [8] = '{4'hD, 4'hB, 4'h9, 4'h7, 4'h5, 4'h3, 4'h1, 4'hF};
  logic [WIDTH-1:0] zeros [8] = '{default: '0};

  initial begin
    rst       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sof       = 1'b0;

    // 1. Reset with inputs toggling, checked before any clock edge.
    #1;
    rst       = 1'b1;
    din       = 4'hA;
    din_valid = 1'b1;
    sof       = 1'b1;
    #1;
    check_y("t1", zeros);
    check("t1_frame_valid", frame_valid, 1'b0);
    check("t1_locked", locked, 1'b0);
    check("t1_sync_err", sync_err, 1'b0);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
    cmp_en    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 2. Plain frame.
    for (int i = 0; i < 8; i++) begin
      beat(f2[i], (i == 0));
      check("t2_locked", locked, 1'b1);
      check("t2_fv", frame_valid, (i == 7));
    end
    check_y("t2", f2);
    idle(1);
    check("t2_fv_one_cycle", frame_valid, 1'b0);

    // 3. Frame with idle gaps, then a back-to-back frame.
    fv_cycles.delete();
    for (int i = 0; i < 8; i++) begin
      beat(f3[i], (i == 0));
      if (i == 1 || i == 4) idle(2);
    end
    check_y("t3a", f3);
    for (int i = 0; i < 8; i++) beat(f3b[i], (i == 0));
    check_y("t3b", f3b);
    idle(1);
    check("t3_fv_count", fv_cycles.size(), 2);
    if (fv_cycles.size() == 2)
      check("t3_fv_spacing", fv_cycles[1] - fv_cycles[0], 8);

    // 4. Early sof on the 4th beat restarts the frame with that beat.
    beat(4'h9, 1'b1);
    beat(4'h8, 1'b0);
    beat(4'h7 ^ 4'h1, 1'b0);
    beat(f4[0], 1'b1);
    check("t4_sync_err", sync_err, 1'b1);
    check("t4_locked", locked, 1'b1);
    check_y("t4_hold", f3b);
    for (int i = 1; i < 8; i++) beat(f4[i], 1'b0);
    check("t4_fv", frame_valid, 1'b1);
    check_y("t4", f4);

    // 5. Missing sof after a good frame drops lock; sof relocks.
    beat(4'h2, 1'b0);
    check("t5_sync_err", sync_err, 1'b1);
    check("t5_locked", locked, 1'b0);
    beat(4'h3, 1'b0);
    check("t5_ignored_err", sync_err, 1'b0);
    beat(4'h4, 1'b0);
    check("t5_ignored_locked", locked, 1'b0);
    beat(4'hC, 1'b1);
    check("t5_relock", locked, 1'b1);
    check("t5_relock_err", sync_err, 1'b0);

    // 6. Reset after 5 beats of a frame (one beat already sent above).
    for (int i = 0; i < 4; i++) beat(4'(i + 1), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_y("t6_rst", zeros);
    check("t6_rst_locked", locked, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) beat(f6[i], (i == 0));
    check("t6_fv", frame_valid, 1'b1);
    check_y("t6", f6);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net: the directed sequence is short, so this only fires on a hang.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
